// File: rtl/jtpopeye_scan2x.sv
// Line-doubling scan converter: 15 kHz RGB 3-3-2 in, 31 kHz out, using a ping-pong pair of line banks.
// Line length and HS width are measured from the incoming timing every line.
module jtpopeye_scan2x #(
  parameter int AW = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_cen,
  input  logic       dbl_cen,
  input  logic [2:0] red,
  input  logic [2:0] green,
  input  logic [1:0] blue,
  input  logic       HS,
  input  logic       VS,
  input  logic       HB,
  input  logic       VB,
  output logic [2:0] x2_red,
  output logic [2:0] x2_green,
  output logic [1:0] x2_blue,
  output logic       x2_HS,
  output logic       x2_VS
);

  localparam logic [AW-1:0] MAX = '1;
  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [7:0]    r_mem [0:(2**(AW+1))-1];

  logic          r_hs_last;
  logic [AW-1:0] r_hcnt;
  logic [AW-1:0] r_hscnt;
  logic [AW-1:0] r_len;
  logic [AW-1:0] r_hsw;
  logic          r_wbank;
  logic          r_vs_lat;
  logic          r_seen;
  logic          r_valid;

  logic [AW-1:0] r_rcnt;
  logic [7:0]    r_rd;
  logic          r_out_en;
  logic          r_x2_hs;
  logic          r_x2_vs;

  logic          w_hs_rise;
  logic          w_hs_fall;
  logic [AW-1:0] w_hcnt_inc;
  logic          w_rd_wrap;

  assign w_hs_rise  = pix_cen & HS & ~r_hs_last;
  assign w_hs_fall  = pix_cen & ~HS & r_hs_last;
  assign w_hcnt_inc = (r_hcnt == MAX) ? MAX : r_hcnt + ONE;
  assign w_rd_wrap  = (r_len == '0) || (r_rcnt >= r_len - ONE);

  // Write side: measure the line, fill the current bank, swap banks on every HS rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_last <= 1'b0;
      r_hcnt    <= '0;
      r_hscnt   <= '0;
      r_len     <= '0;
      r_hsw     <= '0;
      r_wbank   <= 1'b0;
      r_vs_lat  <= 1'b0;
      r_seen    <= 1'b0;
      r_valid   <= 1'b0;
    end else if (pix_cen) begin
      r_hs_last <= HS;
      if (w_hs_rise) begin
        // The rise tick is itself the first HS-high tick, so the width count restarts at one.
        r_len    <= w_hcnt_inc;
        r_hcnt   <= '0;
        r_hscnt  <= ONE;
        r_wbank  <= ~r_wbank;
        r_vs_lat <= VS;
        r_seen   <= 1'b1;
        r_valid  <= r_valid | r_seen;
      end else begin
        r_hcnt <= w_hcnt_inc;
        if (HS && (r_hscnt != MAX)) r_hscnt <= r_hscnt + ONE;
        if (w_hs_fall) r_hsw <= r_hscnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (pix_cen) r_mem[{r_wbank, r_hcnt}] <= (HB | VB) ? 8'd0 : {red, green, blue};
  end

  // Read side: the other bank is replayed at double rate; an input HS rise always restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcnt <= '0;
    end else if (w_hs_rise) begin
      r_rcnt <= '0;
    end else if (dbl_cen) begin
      r_rcnt <= w_rd_wrap ? '0 : r_rcnt + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (dbl_cen) r_rd <= r_mem[{~r_wbank, r_rcnt}];
  end

  // Sync and enable share the read-data pipeline stage so HS stays aligned with pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_en <= 1'b0;
      r_x2_hs  <= 1'b0;
      r_x2_vs  <= 1'b0;
    end else if (dbl_cen) begin
      r_out_en <= r_valid;
      r_x2_hs  <= r_valid & (r_rcnt < r_hsw);
      if (r_rcnt == '0) r_x2_vs <= r_valid & r_vs_lat;
    end
  end

  assign x2_red   = r_out_en ? r_rd[7:5] : 3'd0;
  assign x2_green = r_out_en ? r_rd[4:2] : 3'd0;
  assign x2_blue  = r_out_en ? r_rd[1:0] : 2'd0;
  assign x2_HS    = r_x2_hs;
  assign x2_VS    = r_x2_vs;

endmodule

// File: tb/tb_jtpopeye_scan2x.sv
// Bench for jtpopeye_scan2x: line-level stimulus, per-clock expected outputs queued from a reference model.
module tb_jtpopeye_scan2x;

  localparam int AW   = 9;
  localparam int AMAX = 511;
  localparam int HSW  = 32;

  logic       clk = 1'b0;
  logic       rst_n, pix_cen, dbl_cen;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       HS, VS, HB, VB;
  logic [2:0] x2_red, x2_green;
  logic [1:0] x2_blue;
  logic       x2_HS, x2_VS;

  // Clock / reset
  always #5 clk = ~clk;

  jtpopeye_scan2x #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_cen(pix_cen), .dbl_cen(dbl_cen),
    .red(red), .green(green), .blue(blue),
    .HS(HS), .VS(VS), .HB(HB), .VB(VB),
    .x2_red(x2_red), .x2_green(x2_green), .x2_blue(x2_blue),
    .x2_HS(x2_HS), .x2_VS(x2_VS)
  );

  // Scoreboard: {rgb[7:0], x2_HS, x2_VS}
  logic [9:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  string phase = "reset";

  // Reference model state
  logic [7:0] m_mem [0:1023];
  int   m_r, m_len, m_hsw, m_hscnt, m_w;
  logic m_wb, m_vs, m_valid, m_seen, m_hs_last;

  task automatic check_eq(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [9:0] dut_out();
    return {x2_red, x2_green, x2_blue, x2_HS, x2_VS};
  endfunction

  task automatic model_reset();
    m_r = 0; m_len = 0; m_hsw = 0; m_hscnt = 0; m_w = 0;
    m_wb = 1'b0; m_vs = 1'b0; m_valid = 1'b0; m_seen = 1'b0; m_hs_last = 1'b0;
  endtask

  // Expected output for the coming edge is taken from pre-edge state, then the model advances.
  task automatic model_edge(input logic pc, input logic hs, input logic vs,
                            input logic blank, input logic [7:0] pix);
    logic rise, fall;
    int   ra, wa;
    ra = (m_wb ? 0 : 512) + m_r;
    exp_q.push_back(m_valid ? {m_mem[ra], (m_r < m_hsw), m_vs} : 10'd0);
    rise = pc && hs && !m_hs_last;
    fall = pc && !hs && m_hs_last;
    if (rise || m_len == 0 || m_r >= m_len - 1) m_r = 0;
    else m_r++;
    if (pc) begin
      wa = (m_wb ? 512 : 0) + m_w;
      m_mem[wa] = blank ? 8'd0 : pix;
      if (rise) begin
        m_len   = (m_w + 1 > AMAX) ? AMAX : m_w + 1;
        m_w     = 0;
        m_hscnt = 1;
        m_wb    = ~m_wb;
        m_vs    = vs;
        m_valid = m_valid | m_seen;
        m_seen  = 1'b1;
      end else begin
        if (m_w < AMAX) m_w++;
        if (hs && m_hscnt < AMAX) m_hscnt++;
        if (fall) m_hsw = m_hscnt;
      end
      m_hs_last = hs;
    end
  endtask

  // Driver: one clock with the given enables and inputs, then compare against the queue head.
  task automatic clock_edge(input logic pc, input logic hs, input logic vs, input logic hb,
                            input logic vb, input logic [7:0] pix);
    logic [9:0] e;
    pix_cen = pc; dbl_cen = 1'b1;
    HS = hs; VS = vs; HB = hb; VB = vb;
    {red, green, blue} = pix;
    model_edge(pc, hs, vs, hb | vb, pix);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq(phase, dut_out(), e);
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check_eq("rst_async", dut_out(), 10'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_hold", dut_out(), 10'd0);
    end
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
  endtask

  // Pixel i sits on tick i; the last tick carries the HS rise that starts the next line.
  task automatic drive_line(input int n, input logic lead, input logic vs, input logic vb,
                            input int hb_lo, input int hb_hi, input int mode,
                            input int rst_at, input string tag);
    logic       hs, hb;
    logic [7:0] pix;
    phase = tag;
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) reset_mid();
      hs = (i == n - 1) || (lead && i < HSW - 1);
      hb = (i >= hb_lo) && (i < hb_hi);
      case (mode)
        0:       pix = 8'(i);
        1:       pix = 8'(i) ^ 8'hA5;
        default: pix = 8'($urandom_range(0, 255));
      endcase
      clock_edge(1'b1, hs, vs, hb, vb, pix);
      clock_edge(1'b0, hs, vs, hb, vb, pix);
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_cen = 1'b0; dbl_cen = 1'b0;
    red = '0; green = '0; blue = '0;
    HS = 1'b0; VS = 1'b0; HB = 1'b0; VB = 1'b0;
    for (int a = 0; a < 1024; a++) m_mem[a] = 8'd0;
    model_reset();
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("reset", dut_out(), 10'd0);
    end
    rst_n = 1'b1;

    //          n    lead vs    vb    hb_lo hb_hi mode rst  tag (what the output window shows)
    drive_line(50,  1'b0, 1'b0, 1'b0, 0,  0,  2, -1, "prime");
    drive_line(400, 1'b1, 1'b0, 1'b0, 0,  0,  0, -1, "pre_valid");
    drive_line(400, 1'b1, 1'b0, 1'b0, 0,  80, 1, -1, "basic");
    drive_line(600, 1'b1, 1'b0, 1'b0, 0,  0,  2, -1, "blank");
    drive_line(600, 1'b1, 1'b0, 1'b0, 0,  0,  2, -1, "ovf");
    drive_line(300, 1'b1, 1'b1, 1'b0, 0,  0,  2, -1, "ovf_short");
    drive_line(400, 1'b1, 1'b1, 1'b0, 0,  0,  2, -1, "long_after_short");
    drive_line(350, 1'b1, 1'b1, 1'b0, 0,  0,  2, -1, "vs_1");
    drive_line(400, 1'b1, 1'b0, 1'b0, 0,  0,  2, -1, "vs_2");
    drive_line(400, 1'b1, 1'b0, 1'b1, 0,  0,  2, -1, "vs_3");
    drive_line(400, 1'b1, 1'b0, 1'b0, 0,  0,  0, 200, "vb_line_rst");
    drive_line(400, 1'b1, 1'b0, 1'b0, 0,  0,  2, -1, "post_rst1");
    drive_line(400, 1'b1, 1'b0, 1'b0, 0,  0,  1, -1, "post_rst2");
    drive_line(300, 1'b1, 1'b0, 1'b0, 0,  0,  2, -1, "recover");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
